// File: rtl/core_param_pkg.sv
// Shared opcode constants, FSM state encoding and decode helpers
// for the core_param accumulator machine.
package core_param_pkg;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LDA = 4'h1;
  localparam logic [3:0] OP_STA = 4'h2;
  localparam logic [3:0] OP_ADD = 4'h3;
  localparam logic [3:0] OP_SUB = 4'h4;
  localparam logic [3:0] OP_LDI = 4'h5;
  localparam logic [3:0] OP_JMP = 4'h6;
  localparam logic [3:0] OP_JZ  = 4'h7;
  localparam logic [3:0] OP_INC = 4'h8;
  localparam logic [3:0] OP_HLT = 4'hF;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_MEM_RD,
    S_MEM_WR,
    S_EXEC,
    S_HALT
  } state_t;

  function automatic logic is_mem_rd(input logic [3:0] opc);
    return (opc == OP_LDA) || (opc == OP_ADD) || (opc == OP_SUB);
  endfunction

endpackage

// File: rtl/core_param_alu.sv
// Combinational accumulator datapath: next ACC value, write enable
// and the zero flag that accompanies it.
module core_param_alu #(
  parameter int DATA_W = 16
) (
  input  logic [3:0]        opc,
  input  logic [DATA_W-1:0] acc,
  input  logic [DATA_W-1:0] mdr,
  input  logic [DATA_W-1:0] imm,
  output logic [DATA_W-1:0] res,
  output logic              acc_we,
  output logic              z
);
  import core_param_pkg::*;

  always_comb begin
    res    = acc;
    acc_we = 1'b0;
    case (opc)
      OP_LDA: begin res = mdr;        acc_we = 1'b1; end
      OP_ADD: begin res = acc + mdr;  acc_we = 1'b1; end
      OP_SUB: begin res = acc - mdr;  acc_we = 1'b1; end
      OP_LDI: begin res = imm;        acc_we = 1'b1; end
      OP_INC: begin res = acc + 1'b1; acc_we = 1'b1; end
      default: ;
    endcase
  end

  assign z = (res == '0);

endmodule

// File: rtl/core_param.sv
// Multi-cycle accumulator core: fetch/decode/memory/execute FSM
// with per-access wait timeout and sticky fault.
module core_param #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 9,
  parameter int WAIT_MAX = 15
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  output logic [ADDR_W-1:0] iram_addr,
  output logic              iram_rden,
  input  logic [ADDR_W+3:0] iram_rdata,
  input  logic              iram_ready,
  output logic [ADDR_W-1:0] dram_addr,
  output logic              dram_rden,
  output logic              dram_wren,
  output logic [DATA_W-1:0] dram_wdata,
  input  logic [DATA_W-1:0] dram_rdata,
  input  logic              dram_ready,
  output logic [ADDR_W-1:0] pc_out,
  output logic [DATA_W-1:0] acc_out,
  output logic              busy,
  output logic              halted,
  output logic              fault
);
  import core_param_pkg::*;

  localparam int INSTR_W = 4 + ADDR_W;
  localparam int CNT_W   = $clog2(WAIT_MAX + 2);

  state_t              state, state_n;
  logic [ADDR_W-1:0]   pc;
  logic [INSTR_W-1:0]  ir;
  logic [DATA_W-1:0]   acc, mdr;
  logic                z;
  logic [CNT_W-1:0]    wait_cnt;
  logic [3:0]          opc;
  logic [ADDR_W-1:0]   opr;
  logic [DATA_W-1:0]   alu_res;
  logic                alu_we, alu_z;
  logic                mem_wait, wait_last, timeout, launch;

  assign opc = ir[INSTR_W-1:ADDR_W];
  assign opr = ir[ADDR_W-1:0];

  core_param_alu #(.DATA_W(DATA_W)) u_alu (
    .opc    (opc),
    .acc    (acc),
    .mdr    (mdr),
    .imm    (DATA_W'(opr)),
    .res    (alu_res),
    .acc_we (alu_we),
    .z      (alu_z)
  );

  assign mem_wait = ((state == S_FETCH)  && !iram_ready) ||
                    ((state == S_MEM_RD) && !dram_ready) ||
                    ((state == S_MEM_WR) && !dram_ready);
  assign wait_last = (wait_cnt == CNT_W'(WAIT_MAX));
  assign timeout   = mem_wait && wait_last;
  assign launch    = ((state == S_IDLE) || (state == S_HALT)) && start;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE, S_HALT:
        if (start) state_n = S_FETCH;
      S_FETCH:
        if (iram_ready)     state_n = S_DECODE;
        else if (wait_last) state_n = S_HALT;
      S_DECODE:
        unique case (1'b1)
          is_mem_rd(opc):  state_n = S_MEM_RD;
          (opc == OP_STA): state_n = S_MEM_WR;
          (opc == OP_HLT): state_n = S_HALT;
          default:         state_n = S_EXEC;
        endcase
      S_MEM_RD:
        if (dram_ready)     state_n = S_EXEC;
        else if (wait_last) state_n = S_HALT;
      S_MEM_WR:
        if (dram_ready)     state_n = S_FETCH;
        else if (wait_last) state_n = S_HALT;
      S_EXEC:
        state_n = S_FETCH;
      default:
        state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pc       <= '0;
      ir       <= '0;
      acc      <= '0;
      mdr      <= '0;
      z        <= 1'b0;
      wait_cnt <= '0;
      fault    <= 1'b0;
    end else begin
      wait_cnt <= (mem_wait && !wait_last) ? wait_cnt + 1'b1 : '0;
      if (launch) begin
        pc    <= '0;
        fault <= 1'b0;
      end
      if (timeout) fault <= 1'b1;
      if ((state == S_FETCH) && iram_ready) begin
        ir <= iram_rdata;
        pc <= pc + 1'b1;
      end
      if ((state == S_MEM_RD) && dram_ready) mdr <= dram_rdata;
      if (state == S_EXEC) begin
        if (alu_we) begin
          acc <= alu_res;
          z   <= alu_z;
        end
        if ((opc == OP_JMP) || ((opc == OP_JZ) && z)) pc <= opr;
      end
    end
  end

  assign iram_addr  = pc;
  assign iram_rden  = (state == S_FETCH);
  assign dram_addr  = opr;
  assign dram_rden  = (state == S_MEM_RD);
  assign dram_wren  = (state == S_MEM_WR);
  assign dram_wdata = acc;
  assign pc_out     = pc;
  assign acc_out    = acc;
  assign busy       = (state != S_IDLE) && (state != S_HALT);
  assign halted     = (state == S_HALT);

endmodule

// File: tb/tb_core_param.sv
// Self-checking bench for core_param: directed programs plus random
// programs compared against an instruction-level reference model.
module tb_core_param;

  localparam int DW = 16;
  localparam int AW = 9;
  localparam int IW = 13;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] iram_addr, dram_addr, pc_out;
  logic          iram_rden, iram_ready;
  logic [IW-1:0] iram_rdata;
  logic          dram_rden, dram_wren, dram_ready;
  logic [DW-1:0] dram_wdata, dram_rdata, acc_out;
  logic          busy, halted, fault;

  core_param dut (
    .clock(clock), .reset(reset), .start(start),
    .iram_addr(iram_addr), .iram_rden(iram_rden),
    .iram_rdata(iram_rdata), .iram_ready(iram_ready),
    .dram_addr(dram_addr), .dram_rden(dram_rden),
    .dram_wren(dram_wren), .dram_wdata(dram_wdata),
    .dram_rdata(dram_rdata), .dram_ready(dram_ready),
    .pc_out(pc_out), .acc_out(acc_out), .busy(busy),
    .halted(halted), .fault(fault)
  );

  always #5 clock = ~clock;

  logic [IW-1:0] imem [512];
  logic [DW-1:0] dmem [512];
  logic [DW-1:0] ref_dmem [512];
  logic [DW-1:0] ref_acc;
  logic          ref_z;
  logic [AW-1:0] fetch_log [$];

  int  n_total = 0;
  int  n_bad   = 0;
  int  i_stall = 0;
  int  d_stall = 0;
  int  i_streak = 0;
  int  d_streak = 0;
  int  both_hi = 0;
  bit  rnd_rdy = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  function automatic logic [IW-1:0] ins(input int op, input int o);
    return {4'(op), 9'(o)};
  endfunction

  // memory responder: decides ready away from the active edge
  initial begin
    iram_ready = 1'b0;
    dram_ready = 1'b0;
    iram_rdata = '0;
    dram_rdata = '0;
    forever begin
      @(negedge clock);
      if (dram_rden && dram_wren) both_hi++;
      iram_ready = 1'b0;
      if (iram_rden) begin
        if (i_stall > 0) i_stall--;
        else if (rnd_rdy && i_streak < 4 && $urandom_range(0, 2) == 0)
          i_streak++;
        else begin
          iram_ready = 1'b1;
          i_streak = 0;
        end
      end
      iram_rdata = iram_ready ? imem[iram_addr] : IW'($urandom);
      if (iram_ready) fetch_log.push_back(iram_addr);
      dram_ready = 1'b0;
      if (dram_rden || dram_wren) begin
        if (d_stall > 0) d_stall--;
        else if (rnd_rdy && d_streak < 4 && $urandom_range(0, 2) == 0)
          d_streak++;
        else begin
          dram_ready = 1'b1;
          d_streak = 0;
        end
      end
      dram_rdata = (dram_ready && dram_rden) ? dmem[dram_addr]
                                             : DW'($urandom);
      if (dram_ready && dram_wren) dmem[dram_addr] = dram_wdata;
    end
  end

  task automatic clear_imem();
    for (int i = 0; i < 512; i++) imem[i] = ins(15, 0);
  endtask

  // instruction-level reference: plain ISA semantics and latency table
  task automatic model_run(output logic [AW-1:0] m_pc, output int m_cyc);
    logic [AW-1:0] pc;
    logic [3:0]    opc;
    logic [AW-1:0] o;
    bit            done;
    pc = '0;
    done = 1'b0;
    m_cyc = 0;
    ref_dmem = dmem;
    for (int s = 0; s < 4000 && !done; s++) begin
      opc = imem[pc][12:9];
      o   = imem[pc][8:0];
      pc  = pc + 1'b1;
      case (opc)
        4'h1: begin ref_acc = ref_dmem[o]; ref_z = (ref_acc == 0); m_cyc += 4; end
        4'h2: begin ref_dmem[o] = ref_acc; m_cyc += 3; end
        4'h3: begin ref_acc = ref_acc + ref_dmem[o]; ref_z = (ref_acc == 0); m_cyc += 4; end
        4'h4: begin ref_acc = ref_acc - ref_dmem[o]; ref_z = (ref_acc == 0); m_cyc += 4; end
        4'h5: begin ref_acc = DW'(o); ref_z = (ref_acc == 0); m_cyc += 3; end
        4'h6: begin pc = o; m_cyc += 3; end
        4'h7: begin if (ref_z) pc = o; m_cyc += 3; end
        4'h8: begin ref_acc = ref_acc + 1'b1; ref_z = (ref_acc == 0); m_cyc += 3; end
        4'hF: begin m_cyc += 2; done = 1'b1; end
        default: m_cyc += 3;
      endcase
    end
    m_pc = pc;
  endtask

  task automatic run(output int cyc);
    @(negedge clock);
    start = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
    cyc = 0;
    while (!halted && cyc < 3000) begin
      @(posedge clock);
      #1;
      cyc++;
    end
    chk("halt_reached", 32'(halted), 1);
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_pc"},     32'(pc_out), 0);
    chk({tag, "_acc"},    32'(acc_out), 0);
    chk({tag, "_busy"},   32'(busy), 0);
    chk({tag, "_halted"}, 32'(halted), 0);
    chk({tag, "_fault"},  32'(fault), 0);
    chk({tag, "_strobes"}, {29'd0, iram_rden, dram_rden, dram_wren}, 0);
  endtask

  initial begin
    logic [AW-1:0] mpc;
    int mcyc, cyc, n_rd, bad_addr, len, op, o;

    clear_imem();
    for (int i = 0; i < 512; i++) dmem[i] = '0;
    ref_acc = '0;
    ref_z = 1'b0;

    repeat (3) @(negedge clock);
    chk_reset_outs("rst");
    reset = 1'b0;
    @(negedge clock);
    chk_reset_outs("idle");

    // LDI 5; INC; STA 3; HALT with zero wait
    imem[0] = ins(5, 5);
    imem[1] = ins(8, 0);
    imem[2] = ins(2, 3);
    imem[3] = ins(15, 0);
    model_run(mpc, mcyc);
    run(cyc);
    chk("p1_cycles", cyc, 11);
    chk("p1_acc", 32'(acc_out), 6);
    chk("p1_m3", 32'(dmem[3]), 6);
    chk("p1_pc", 32'(pc_out), 4);
    chk("p1_model_cyc", cyc, mcyc);

    // wrap-around arithmetic and zero flag
    clear_imem();
    dmem[2] = 16'hFFFF;
    imem[0] = ins(1, 2);
    imem[1] = ins(3, 2);
    imem[2] = ins(2, 5);
    imem[3] = ins(7, 32);
    imem[4] = ins(4, 2);
    imem[5] = ins(2, 4);
    imem[6] = ins(5, 0);
    imem[7] = ins(7, 16);
    model_run(mpc, mcyc);
    run(cyc);
    chk("p2_add_wrap", 32'(dmem[5]), 32'hFFFE);
    chk("p2_sub_wrap", 32'(dmem[4]), 32'hFFFF);
    chk("p2_acc", 32'(acc_out), 0);
    chk("p2_jz_taken_pc", 32'(pc_out), 17);
    chk("p2_model_pc", 32'(pc_out), 32'(mpc));

    // data memory stall during LDA
    clear_imem();
    dmem[5] = 16'h1234;
    imem[0] = ins(1, 5);
    model_run(mpc, mcyc);
    d_stall = 3;
    n_rd = 0;
    bad_addr = 0;
    @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    for (int c = 0; c < 40 && !halted; c++) begin
      @(negedge clock);
      if (dram_rden) begin
        n_rd++;
        if (dram_addr != 9'd5) bad_addr++;
      end
    end
    chk("p3_rden_cycles", n_rd, 4);
    chk("p3_addr_stable", bad_addr, 0);
    chk("p3_acc", 32'(acc_out), 32'h1234);
    chk("p3_halted", 32'(halted), 1);

    // instruction fetch timeout
    i_stall = 1000;
    run(cyc);
    chk("p4_timeout_cycles", cyc, 16);
    chk("p4_fault", 32'(fault), 1);
    chk("p4_strobes", {30'd0, iram_rden, dram_rden}, 0);
    chk("p4_busy", 32'(busy), 0);
    i_stall = 0;
    clear_imem();
    imem[0] = ins(5, 5);
    imem[1] = ins(8, 0);
    imem[2] = ins(2, 3);
    dmem[3] = '0;
    fetch_log.delete();
    model_run(mpc, mcyc);
    run(cyc);
    chk("p4_fault_cleared", 32'(fault), 0);
    chk("p4_first_fetch", 32'(fetch_log[0]), 0);
    chk("p4_acc", 32'(acc_out), 6);

    // reset during a stalled store
    clear_imem();
    imem[0] = ins(2, 7);
    dmem[7] = 16'hABCD;
    d_stall = 10;
    @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    for (int c = 0; c < 20 && !dram_wren; c++) @(negedge clock);
    chk("p5_wren_seen", 32'(dram_wren), 1);
    @(negedge clock);
    #2 reset = 1'b1;
    #1;
    chk_reset_outs("p5");
    @(negedge clock);
    reset = 1'b0;
    d_stall = 0;
    ref_acc = '0;
    ref_z = 1'b0;
    @(negedge clock);
    chk("p5_mem_kept", 32'(dmem[7]), 32'hABCD);

    // PC wrap from the top of instruction space
    clear_imem();
    imem[0]   = ins(7, 5);
    imem[1]   = ins(5, 0);
    imem[2]   = ins(6, 511);
    imem[511] = ins(0, 0);
    fetch_log.delete();
    model_run(mpc, mcyc);
    run(cyc);
    chk("p6_fetch_n", fetch_log.size(), 6);
    if (fetch_log.size() == 6) begin
      chk("p6_f3", 32'(fetch_log[3]), 511);
      chk("p6_wrap", 32'(fetch_log[4]), 0);
      chk("p6_f5", 32'(fetch_log[5]), 5);
    end
    chk("p6_pc", 32'(pc_out), 32'(mpc));

    // random programs with forward-only branches
    for (int k = 0; k < 24; k++) begin
      rnd_rdy = k[0];
      clear_imem();
      len = $urandom_range(4, 20);
      for (int i = 0; i < len - 1; i++) begin
        op = $urandom_range(0, 15);
        o  = $urandom_range(0, 15);
        if (op == 5) o = $urandom_range(0, 511);
        if (op == 6 || op == 7) o = $urandom_range(i + 1, len - 1);
        imem[i] = ins(op, o);
      end
      for (int j = 0; j < 16; j++) dmem[j] = DW'($urandom);
      if (k % 4 == 0) dmem[$urandom_range(0, 15)] = '0;
      model_run(mpc, mcyc);
      run(cyc);
      chk("rnd_acc", 32'(acc_out), 32'(ref_acc));
      chk("rnd_pc", 32'(pc_out), 32'(mpc));
      chk("rnd_fault", 32'(fault), 0);
      if (!rnd_rdy) chk("rnd_cycles", cyc, mcyc);
      for (int j = 0; j < 16; j++) chk("rnd_mem", 32'(dmem[j]), 32'(ref_dmem[j]));
    end

    chk("rden_wren_exclusive", both_hi, 0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
